led_pwm_dimmer: RTL

- Downstream consumer of the red-LED PIO output port.
- Takes the 18-bit LED pattern and drives the physical LED pins with a global PWM brightness and an optional blink gate.
- Has its own small Avalon-MM slave (zero wait states, read latency 0), so the CPU can set brightness and blink rate without changing the pattern.
- Placed between the PIO out_port and the top-level LEDR pins.

---
 rtl/led_pwm_dimmer.sv | 109 ++++++++++
 1 files changed

// File: rtl/led_pwm_dimmer.sv
// LED dimmer placed between the LED PIO and the board pins: global PWM brightness
// plus an optional blink gate, programmed through a small Avalon-MM slave.
`timescale 1ns/1ps
module led_pwm_dimmer #(
    parameter int WIDTH    = 18,
    parameter int PRESCALE = 50,
    parameter int BLINK_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] led_out
);

    localparam int PS_W = 16;

    logic [1:0]         ctrl;
    logic [7:0]         duty;
    logic [BLINK_W-1:0] blink_period;
    logic [PS_W-1:0]    prescaler;
    logic [7:0]         pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;
    logic [WIDTH-1:0]   led_in_q;

    logic enable, blink_en;
    logic wr_en, wr_ctrl, wr_duty, wr_blink, enable_rise;
    logic tick, period_end, pwm_on, gate;
    logic unused_wd;

    assign enable    = ctrl[0];
    assign blink_en  = ctrl[1];
    assign unused_wd = &{1'b0, writedata};

    always_comb begin
        wr_en       = chipselect && !write_n;
        wr_ctrl     = wr_en && (address == 2'd0);
        wr_duty     = wr_en && (address == 2'd1);
        wr_blink    = wr_en && (address == 2'd2);
        enable_rise = wr_ctrl && writedata[0] && !enable;
        tick        = enable && (prescaler == PS_W'(PRESCALE - 1));
        period_end  = tick && (pwm_cnt == 8'hFF);
        pwm_on      = (duty == 8'hFF) || (pwm_cnt < duty);
        gate        = pwm_on && (!blink_en || phase);
    end

    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0:    readdata = {30'h0, ctrl};
            2'd1:    readdata = {24'h0, duty};
            2'd2:    readdata = 32'(blink_period);
            default: readdata = {16'h0, pwm_cnt, 7'h0, phase};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl         <= 2'b00;
            duty         <= 8'hFF;
            blink_period <= '0;
            prescaler    <= '0;
            pwm_cnt      <= 8'h00;
            blink_cnt    <= '0;
            phase        <= 1'b1;
            led_in_q     <= '0;
            led_out      <= '0;
        end else begin
            // two-stage path: input capture, then gated output register
            led_in_q <= led_in;
            led_out  <= enable ? (led_in_q & {WIDTH{gate}}) : led_in_q;

            if (wr_ctrl)  ctrl         <= writedata[1:0];
            if (wr_duty)  duty         <= writedata[7:0];
            if (wr_blink) blink_period <= writedata[BLINK_W-1:0];

            if (enable_rise || !enable) begin
                prescaler <= '0;
                pwm_cnt   <= 8'h00;
            end else if (tick) begin
                prescaler <= '0;
                pwm_cnt   <= pwm_cnt + 8'd1;
            end else begin
                prescaler <= prescaler + PS_W'(1);
            end

            // register writes take priority over a coincident period_end
            if (enable_rise || wr_blink || (blink_period == '0)) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (!enable) begin
                blink_cnt <= '0;
            end else if (period_end) begin
                if (blink_cnt == blink_period - BLINK_W'(1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

endmodule
